// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   - UART_OVERSAMPLE_DEFAULT : default sampling-clock cycles per bit
//   - rx_state_e              : receiver FSM states
//   - PROTO_*                 : protocol byte constants used by the
//                               downstream protocol stage
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        s_idle      = 3'd0,
        s_start     = 3'd1,
        s_data      = 3'd2,
        s_parity    = 3'd3,
        s_stop      = 3'd4,
        s_wait_idle = 3'd5
    } rx_state_e;

    localparam logic [7:0] PROTO_START = 8'hAA;
    localparam logic [7:0] PROTO_TRAIN = 8'h55;
    localparam logic [7:0] PROTO_TEST  = 8'hC3;
    localparam logic [7:0] PROTO_STOP  = 8'h3C;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RESET_VAL into both flops
//   d    - asynchronous input
//   q    - synchronized output
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, one stop bit, oversampled.
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit
// after the data bits; without it parity_err is constant 0.
// Ports:
//   uart_sampling_clk - clock at OVERSAMPLE x baud
//   rst               - synchronous active-high reset
//   rx                - asynchronous serial line, idle high
//   uart_byte         - last correctly received byte
//   data_rdy          - one-cycle pulse, uart_byte newly valid
//   framing_err       - one-cycle pulse, stop bit sampled low
//   parity_err        - one-cycle pulse, parity mismatch
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic       uart_sampling_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_byte,
    output logic       data_rdy,
    output logic       framing_err,
    output logic       parity_err
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            rdy_q, rdy_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (uart_sampling_clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            s_idle: begin
                if (!rx_s) begin
                    state_d = s_start;
                    cnt_d   = '0;
                end
            end
            // Start bit is re-checked at its midpoint; every later sample
            // then lands one full bit period on, i.e. mid-bit.
            s_start: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? s_idle : s_data;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            s_data: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = s_parity;
`else
                        state_d = s_stop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            s_parity: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = s_stop;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            s_stop: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        // Low stop bit wins over any parity mismatch.
                        ferr_d  = 1'b1;
                        state_d = s_wait_idle;
                    end else begin
                        state_d = s_idle;
`ifdef UART_RX_PARITY_EN
                        if (par_q != ^shift_q) begin
                            perr_d = 1'b1;
                        end else begin
                            rdy_d  = 1'b1;
                            byte_d = shift_q;
                        end
`else
                        rdy_d  = 1'b1;
                        byte_d = shift_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Hold off until the line returns high so a break reports once.
            s_wait_idle: begin
                if (rx_s) begin
                    state_d = s_idle;
                end
            end
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge uart_sampling_clk) begin
        if (rst) begin
            state_q <= s_idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign uart_byte   = byte_q;
    assign data_rdy    = rdy_q;
    assign framing_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Cycles from driving the start edge to seeing the outcome pulse:
    // 2 synchronizer stages, 1 cycle to notice the low line, half a bit
    // to mid-start, 8 data bits (+ parity) + stop bit at one period each,
    // and the registered pulse itself.
    localparam int LAT = 2 + 1 + OS / 2 + (9 + PAR) * OS;

    localparam int K_NONE = 0;
    localparam int K_RDY  = 1;
    localparam int K_FERR = 2;
    localparam int K_PERR = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] uart_byte;
    logic       data_rdy;
    logic       framing_err;
    logic       parity_err;

    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    int         rdy_seen = 0;
    ev_t        exp_q[$];
    logic [7:0] model_byte = 8'h00;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .uart_sampling_clk (clk),
        .rst               (rst),
        .rx                (rx),
        .uart_byte         (uart_byte),
        .data_rdy          (data_rdy),
        .framing_err       (framing_err),
        .parity_err        (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Compare process: outputs are checked one step after every rising edge.
    initial begin
        int kind;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                model_byte = 8'h00;
                chk("reset data_rdy", data_rdy, 0);
                chk("reset framing_err", framing_err, 0);
                chk("reset parity_err", parity_err, 0);
                chk("reset uart_byte", uart_byte, 0);
            end else begin
                kind = K_NONE;
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    chk("missed event cycle", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    kind = exp_q[0].kind;
                    if (kind == K_RDY) model_byte = exp_q[0].b;
                    void'(exp_q.pop_front());
                end
                if (data_rdy) rdy_seen++;
                chk("data_rdy", data_rdy, (kind == K_RDY));
                chk("framing_err", framing_err, (kind == K_FERR));
                chk("parity_err", parity_err, (kind == K_PERR));
                chk("uart_byte", uart_byte, model_byte);
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (OS) @(negedge clk);
    endtask

    // Called at a falling edge; schedules the expected outcome, then drives.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_bit, input int low_hold);
        ev_t e;
        e.cyc = cyc + LAT;
        e.b   = b;
        if (!stop_bit) e.kind = K_FERR;
        else if (PAR != 0 && par_bit != ^b) e.kind = K_PERR;
        else e.kind = K_RDY;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR != 0) drive_bit(par_bit);
        drive_bit(stop_bit);
        if (!stop_bit) begin
            rx = 1'b0;
            repeat (low_hold) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b1, ^b, 0);
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(OS);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int         r0;
        int         sel;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(20);

        // Single 0xFF frame.
        r0 = rdy_seen;
        good(8'hFF);
        idle(4);
        chk("FF byte", uart_byte, 8'hFF);
        chk("FF rdy count", rdy_seen - r0, 1);

        // Three frames with no gap.
        r0 = rdy_seen;
        good(8'hFF);
        good(8'hF0);
        good(8'h0F);
        idle(4);
        chk("b2b last byte", uart_byte, 8'h0F);
        chk("b2b rdy count", rdy_seen - r0, 3);

        // Short glitch, then a real frame.
        glitch();
        good(8'hBB);
        idle(4);
        chk("glitch then BB", uart_byte, 8'hBB);

        // Break: stop bit low and line held low.
        good(8'h11);
        idle(4);
        send_frame(8'h5A, 1'b0, ^8'h5A, 40);
        idle(OS);
        chk("framing keeps byte", uart_byte, 8'h11);
        good(8'hBB);
        idle(4);
        chk("after break BB", uart_byte, 8'hBB);

        // Reset in the middle of bit 4 of 0xA5.
        v = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        rx = v[4];
        repeat (OS / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        idle(2 * OS);
        chk("mid-frame rst byte", uart_byte, 8'h00);
        good(8'h3C);
        idle(4);
        chk("after rst 3C", uart_byte, 8'h3C);

`ifdef UART_RX_PARITY_EN
        r0 = rdy_seen;
        send_frame(8'h03, 1'b1, 1'b1, 0);
        idle(4);
        chk("bad parity keeps byte", uart_byte, 8'h3C);
        chk("bad parity no rdy", rdy_seen - r0, 0);
        send_frame(8'h03, 1'b1, 1'b0, 0);
        idle(4);
        chk("good parity 03", uart_byte, 8'h03);
`endif

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            v   = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                glitch();
            end else if (sel == 1) begin
                send_frame(v, 1'b0, ^v, $urandom_range(0, 40));
                idle(OS);
            end else if (sel == 2 && PAR != 0) begin
                send_frame(v, 1'b1, ~(^v), 0);
                idle($urandom_range(0, 3));
            end else begin
                good(v);
                idle($urandom_range(0, 1) * $urandom_range(0, 20));
            end
        end

        idle(LAT + 4);
        chk("pending events", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning sampling-clock cycles per UART bit period (even, >= 8).
REQ-002 SHALL have port uart_sampling_clk, input, 1, meaning the single clock, running at OVERSAMPLE x baud rate.
REQ-003 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-004 SHALL have port rx, input, 1, meaning the asynchronous serial line, idle high.
REQ-005 SHALL have port uart_byte, output, 8, meaning the last correctly received byte.
REQ-006 SHALL have port data_rdy, output, 1, meaning a one-cycle pulse that marks uart_byte as newly valid.
REQ-007 SHALL have port framing_err, output, 1, meaning a one-cycle pulse when a stop bit is sampled low.
REQ-008 SHALL have port parity_err, output, 1, meaning a one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-010 SHALL implement the states s_idle, s_start, s_data, s_parity, s_stop and s_wait_idle.
REQ-011 SHALL, in s_idle, move to s_start with the bit-tick counter cleared when rx_s == 0.
REQ-012 SHALL, in s_start, sample rx_s when the counter reaches OVERSAMPLE/2-1: if rx_s is 0, go to s_data with the counter and bit index cleared; if rx_s is 1, treat it as a glitch and return to s_idle with no output pulse.
REQ-013 SHALL, in s_data, sample rx_s each time the counter reaches OVERSAMPLE-1, then clear the counter.
REQ-014 SHALL, in s_data, shift each sampled bit into the MSB of the shift register (LSB first on the wire).
REQ-015 SHALL, in s_data, leave the state after the 8th sample (bit index 7) and go to s_stop, or to s_parity when parity is enabled.
REQ-016 SHALL, in s_stop, sample rx_s when the counter reaches OVERSAMPLE-1.
REQ-017 SHALL, if that stop sample is 1 and there is no parity error, load uart_byte from the shift register, assert data_rdy for exactly one cycle in the next cycle, and go to s_idle.
REQ-018 SHALL, if that stop sample is 0, assert framing_err for one cycle, leave uart_byte unchanged, assert no data_rdy, and go to s_wait_idle.
REQ-019 SHALL remain in s_wait_idle until rx_s == 1, then go to s_idle; a break condition therefore produces exactly one framing_err.
REQ-020 SHALL hold uart_byte stable between data_rdy pulses.
REQ-021 SHALL keep data_rdy, framing_err and parity_err mutually exclusive, each at most one cycle per frame.
REQ-022 SHALL accept back-to-back frames: a start edge arriving on the first rx_s==0 cycle after a good stop sample begins the next frame with no lost byte.
REQ-023 SHALL use a bit-tick counter of $clog2(OVERSAMPLE) bits, never wrapping mid-bit.

Reset
REQ-024 SHALL, on rst, set state to s_idle, the counter, bit index and shift register to 0, uart_byte to 8'h00, data_rdy, framing_err and parity_err to 0, and both synchronizer flops to 1.
REQ-025 SHALL make rst asserted mid-frame abandon the frame without any pulse; the next frame SHALL be received only from a fresh falling edge after rst is released.

Configuration
REQ-026 SHALL, with UART_RX_PARITY_EN defined, expect an even-parity bit after the data bits, sampled in s_parity at counter OVERSAMPLE-1.
REQ-027 SHALL, with UART_RX_PARITY_EN defined, on parity mismatch assert parity_err for one cycle at the stop sample in place of data_rdy; a mismatch with a low stop bit reports framing_err only.
REQ-028 SHALL, without UART_RX_PARITY_EN, never enter s_parity and tie parity_err to constant 0; the port list is unchanged.

Structure
REQ-029 SHALL place the rx state enum and the OVERSAMPLE default constant in shared package uart_pkg, alongside the START/TRAIN/TEST/STOP protocol byte constants used by the downstream protocol stage.
REQ-030 SHALL implement the two-flop synchronizer as sub-module uart_sync (parameterised reset value), instantiated once.

Verification
REQ-031 SHALL cover: send 8'hFF at 16x -> exactly one data_rdy, uart_byte == 8'hFF, no error pulse.
REQ-032 SHALL cover: send 8'hFF, 8'hF0, 8'h0F back-to-back with zero idle time -> three data_rdy pulses carrying those bytes in order.
REQ-033 SHALL cover: rx low for 4 cycles then high -> no pulse, state returns to s_idle, and a following 8'hBB is received correctly.
REQ-034 SHALL cover: 8'h5A sent with the stop bit driven 0 and rx held low 40 cycles -> one framing_err, uart_byte keeps its previous value, and the next frame 8'hBB is received.
REQ-035 SHALL cover: rst asserted during bit 4 of 8'hA5 -> no pulse and uart_byte == 8'h00; the next 8'h3C is received correctly.
REQ-036 SHALL cover, with UART_RX_PARITY_EN: 8'h03 sent with parity bit 1 -> parity_err only; sent with parity bit 0 -> data_rdy with uart_byte == 8'h03.
